// File: rtl/see_cone_stimulus.sv
// Exhaustive stimulus sweeper for a golden / fault-injected cone pair.
// Optional first-mismatch capture is built only when SEE_FIRST_ERR_EN is defined.
`timescale 1ns/1ps
module see_cone_stimulus #(
  parameter int NIN    = 6,
  parameter int SETTLE = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [3:0]     inj_sel,
  output logic [NIN-1:0] stim,
  output logic [NIN-1:0] stim_f,
  input  logic           gold_in,
  input  logic           fault_in,
  output logic           busy,
  output logic           done,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [NIN-1:0] res_vec,
  output logic           res_err,
  output logic [NIN:0]   err_cnt,
  output logic [NIN-1:0] first_err_vec
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_REPORT,
    ST_FINISH
  } state_t;

  localparam logic [3:0]     SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [NIN-1:0] VEC_LAST    = {NIN{1'b1}};
  localparam logic [NIN:0]   CNT_MAX     = {1'b1, {NIN{1'b0}}};

  state_t         r_state;
  state_t         w_state_next;
  logic [NIN-1:0] r_vec;
  logic [NIN-1:0] w_vec_next;
  logic [3:0]     r_sel;
  logic [3:0]     w_sel_next;
  logic [3:0]     r_cnt;
  logic [NIN-1:0] r_stim;
  logic [NIN-1:0] r_stim_f;
  logic [NIN-1:0] r_res_vec;
  logic           r_res_err;
  logic [NIN:0]   r_err_cnt;
  logic [NIN-1:0] w_mask;
  logic           w_mismatch;
  logic           w_sweep_start;

  // Out-of-range selects leave every mask bit clear, so no line flips.
  genvar gi;
  generate
    for (gi = 0; gi < NIN; gi++) begin : g_mask
      assign w_mask[gi] = ({28'd0, w_sel_next} == gi);
    end
  endgenerate

  assign w_mismatch    = gold_in ^ fault_in;
  assign w_sweep_start = (r_state == ST_IDLE) && start;

  always_comb begin
    w_state_next = r_state;
    w_vec_next   = r_vec;
    w_sel_next   = r_sel;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_DRIVE;
          w_vec_next   = '0;
          w_sel_next   = inj_sel;
        end
      end
      ST_DRIVE:  w_state_next = ST_SETTLE;
      ST_SETTLE: begin
        if (r_cnt == SETTLE_LAST) w_state_next = ST_SAMPLE;
      end
      ST_SAMPLE: w_state_next = ST_REPORT;
      ST_REPORT: begin
        if (res_ready) begin
          if (r_vec == VEC_LAST) begin
            w_state_next = ST_FINISH;
          end else begin
            w_state_next = ST_DRIVE;
            w_vec_next   = r_vec + 1'b1;
          end
        end
      end
      ST_FINISH: w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_vec     <= '0;
      r_sel     <= '0;
      r_cnt     <= '0;
      r_stim    <= '0;
      r_stim_f  <= '0;
      r_res_vec <= '0;
      r_res_err <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_vec   <= w_vec_next;
      r_sel   <= w_sel_next;
      r_cnt   <= (r_state == ST_SETTLE) ? r_cnt + 4'd1 : 4'd0;
      // Stimulus is loaded on DRIVE entry so it is visible during DRIVE.
      if (w_state_next == ST_DRIVE) begin
        r_stim   <= w_vec_next;
        r_stim_f <= w_vec_next ^ w_mask;
      end
      if (w_sweep_start) r_err_cnt <= '0;
      if (r_state == ST_SAMPLE) begin
        r_res_vec <= r_vec;
        r_res_err <= w_mismatch;
        if (w_mismatch && (r_err_cnt != CNT_MAX)) r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

`ifdef SEE_FIRST_ERR_EN
  logic [NIN-1:0] r_first_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_first_err <= '0;
    end else if (w_sweep_start) begin
      r_first_err <= '0;
    end else if ((r_state == ST_SAMPLE) && w_mismatch && (r_err_cnt == '0)) begin
      r_first_err <= r_vec;
    end
  end

  assign first_err_vec = r_first_err;
`else
  assign first_err_vec = '0;
`endif

  assign stim      = r_stim;
  assign stim_f    = r_stim_f;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_FINISH);
  assign res_valid = (r_state == ST_REPORT);
  assign res_vec   = r_res_vec;
  assign res_err   = r_res_err;
  assign err_cnt   = r_err_cnt;

endmodule
